// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Purpose:
//    Shares one fully pipelined mult_line multiplier among NREQ requesters.
//    A round-robin arbiter grants at most one operand pair per cycle. A tag
//    pipeline travels alongside each operation so that the product is
//    returned to the requester that issued it. Responses come back in issue
//    order and have no backpressure.
//
// Optional feature (compile-time macro MULT_ARB_TAG_CHECK_EN):
//    defined   : o_err is set (sticky until i_rst) whenever i_mul_valid
//                disagrees with the last tag stage valid bit; a mul_valid
//                without a matching tag produces no response.
//    undefined : o_err is tied low; responses are gated by i_mul_valid alone
//                and use whatever id sits in the last tag stage.
//
// Ports:
//    i_clk        clock, all logic on the rising edge
//    i_rst        synchronous active-high reset
//    i_en         arbitration enable; low blocks new grants
//    i_req_valid  per-requester request valid
//    i_req_a      packed operand a, requester i at [i*MULTLEN_1 +: MULTLEN_1]
//    i_req_b      packed operand b, requester i at [i*MULTLEN_2 +: MULTLEN_2]
//    o_req_ready  one-hot grant (combinational)
//    o_mul_rdy    to multiplier rdy
//    o_mul_a      to multiplier mult_1
//    o_mul_b      to multiplier mult_2
//    i_mul_dout   from multiplier dout
//    i_mul_valid  from multiplier valid
//    o_rsp_valid  one-hot response strobe, one cycle
//    o_rsp_id     index of the responding requester
//    o_rsp_data   unsigned full-width product
//    o_err        sticky tag-mismatch flag
// -----------------------------------------------------------------------------
module mult_arbiter #(
   parameter int NREQ      = 4,
   parameter int MULTLEN_1 = 8,
   parameter int MULTLEN_2 = 8,
   parameter int MUL_LAT   = 8
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_en,
   input  logic [NREQ-1:0]                i_req_valid,
   input  logic [NREQ*MULTLEN_1-1:0]      i_req_a,
   input  logic [NREQ*MULTLEN_2-1:0]      i_req_b,
   output logic [NREQ-1:0]                o_req_ready,
   output logic                           o_mul_rdy,
   output logic [MULTLEN_1-1:0]           o_mul_a,
   output logic [MULTLEN_2-1:0]           o_mul_b,
   input  logic [MULTLEN_1+MULTLEN_2-1:0] i_mul_dout,
   input  logic                           i_mul_valid,
   output logic [NREQ-1:0]                o_rsp_valid,
   output logic [$clog2(NREQ)-1:0]        o_rsp_id,
   output logic [MULTLEN_1+MULTLEN_2-1:0] o_rsp_data,
   output logic                           o_err
);

   localparam int IDW = $clog2(NREQ);
   localparam int PW  = MULTLEN_1 + MULTLEN_2;
   localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   logic [IDW-1:0]       r_last_grant;
   logic                 r_mul_rdy;
   logic [MULTLEN_1-1:0] r_mul_a;
   logic [MULTLEN_2-1:0] r_mul_b;
   logic [NREQ-1:0]      r_rsp_valid;
   logic [IDW-1:0]       r_rsp_id;
   logic [PW-1:0]        r_rsp_data;
   logic                 r_err;

   // Stage 0 is loaded together with the issue register, so stage k holds the
   // operation k cycles after mul_rdy went high; stage MUL_LAT lines up with
   // the multiplier's mul_valid for that operation.
   logic                 r_tag_vld [0:MUL_LAT];
   logic [IDW-1:0]       r_tag_id  [0:MUL_LAT];

   logic                 w_grant_found;
   logic [IDW-1:0]       w_grant_idx;
   logic [NREQ-1:0]      w_grant_oh;
   logic [MULTLEN_1-1:0] w_sel_a;
   logic [MULTLEN_2-1:0] w_sel_b;
   logic                 w_accept;
   logic                 w_rsp_fire;
   logic                 w_tag_mismatch;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   function automatic logic [NREQ-1:0] f_onehot(input logic [IDW-1:0] id);
      logic [NREQ-1:0] v_oh;
      v_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         v_oh[i] = (IDW'(i) == id);
      end
      return v_oh;
   endfunction

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
   // Round-robin search: first look above the last grant, then wrap to the bottom.
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      w_grant_oh    = '0;
      w_sel_a       = '0;
      w_sel_b       = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_grant_found && i_req_valid[i] && (IDW'(i) > r_last_grant)) begin
            w_grant_found = 1'b1;
            w_grant_idx   = IDW'(i);
            w_grant_oh[i] = 1'b1;
            w_sel_a       = i_req_a[i*MULTLEN_1 +: MULTLEN_1];
            w_sel_b       = i_req_b[i*MULTLEN_2 +: MULTLEN_2];
         end else begin
            w_grant_found = w_grant_found;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!w_grant_found && i_req_valid[i]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = IDW'(i);
            w_grant_oh[i] = 1'b1;
            w_sel_a       = i_req_a[i*MULTLEN_1 +: MULTLEN_1];
            w_sel_b       = i_req_b[i*MULTLEN_2 +: MULTLEN_2];
         end else begin
            w_grant_found = w_grant_found;
         end
      end
   end

   // A grant is only visible (and only counts as an accept) when enabled and out of reset.
   assign w_accept    = w_grant_found & i_en & ~i_rst;
   assign o_req_ready = w_accept ? w_grant_oh : {NREQ{1'b0}};

   // ---------------------------------------------------------------------------
   // Issue register and round-robin pointer
   // ---------------------------------------------------------------------------
   // Launch the granted operands toward the multiplier and remember the winner.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mul_rdy    <= 1'b0;
         r_mul_a      <= '0;
         r_mul_b      <= '0;
         r_last_grant <= LAST_IDX;
      end else if (w_accept) begin
         r_mul_rdy    <= 1'b1;
         r_mul_a      <= w_sel_a;
         r_mul_b      <= w_sel_b;
         r_last_grant <= w_grant_idx;
      end else begin
         r_mul_rdy    <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Tag pipeline
   // ---------------------------------------------------------------------------
   // Shift requester ids alongside the multiplier; it never stalls so neither do we.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k <= MUL_LAT; k++) begin
            r_tag_vld[k] <= 1'b0;
            r_tag_id[k]  <= '0;
         end
      end else begin
         r_tag_vld[0] <= w_accept;
         r_tag_id[0]  <= w_accept ? w_grant_idx : r_tag_id[0];
         for (int k = 1; k <= MUL_LAT; k++) begin
            r_tag_vld[k] <= r_tag_vld[k-1];
            r_tag_id[k]  <= r_tag_id[k-1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Response qualification
   // ---------------------------------------------------------------------------
`ifdef MULT_ARB_TAG_CHECK_EN
   // Only a result that the tag pipe expects is reported; any disagreement is an error.
   assign w_rsp_fire     = i_mul_valid & r_tag_vld[MUL_LAT];
   assign w_tag_mismatch = i_mul_valid ^ r_tag_vld[MUL_LAT];
`else
   assign w_rsp_fire     = i_mul_valid;
   assign w_tag_mismatch = 1'b0;
`endif

   // Register the returning product and route it to the issuing requester.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_valid <= '0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else if (w_rsp_fire) begin
         r_rsp_valid <= f_onehot(r_tag_id[MUL_LAT]);
         r_rsp_id    <= r_tag_id[MUL_LAT];
         r_rsp_data  <= i_mul_dout;
      end else begin
         r_rsp_valid <= '0;
      end
   end

   // Sticky tag-mismatch flag, cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= r_err | w_tag_mismatch;
      end
   end

   assign o_mul_rdy   = r_mul_rdy;
   assign o_mul_a     = r_mul_a;
   assign o_mul_b     = r_mul_b;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_data  = r_rsp_data;
   assign o_err       = r_err;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Directed bench for mult_arbiter with a behavioural pipelined multiplier.
// Expected responses (id, product, due cycle) are queued when a grant is
// expected and popped when the DUT raises rsp_valid.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

   localparam int NREQ = 4;
   localparam int M1   = 8;
   localparam int M2   = 8;
   localparam int LAT  = 8;
   localparam int PW   = M1 + M2;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic [NREQ-1:0]  req_valid;
   logic [NREQ*M1-1:0] req_a;
   logic [NREQ*M2-1:0] req_b;
   logic [NREQ-1:0]  req_ready;
   logic             mul_rdy;
   logic [M1-1:0]    mul_a;
   logic [M2-1:0]    mul_b;
   logic [PW-1:0]    mul_dout;
   logic             mul_valid;
   logic [NREQ-1:0]  rsp_valid;
   logic [1:0]       rsp_id;
   logic [PW-1:0]    rsp_data;
   logic             err;
   logic             force_valid;

   always #5 clk = ~clk;

   mult_arbiter #(
      .NREQ(NREQ), .MULTLEN_1(M1), .MULTLEN_2(M2), .MUL_LAT(LAT)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en),
      .i_req_valid(req_valid), .i_req_a(req_a), .i_req_b(req_b),
      .o_req_ready(req_ready),
      .o_mul_rdy(mul_rdy), .o_mul_a(mul_a), .o_mul_b(mul_b),
      .i_mul_dout(mul_dout), .i_mul_valid(mul_valid),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
      .o_err(err)
   );

   // Behavioural mult_line: LAT register stages, reset together with the arbiter.
   logic          m_vld [0:LAT-1];
   logic [PW-1:0] m_dat [0:LAT-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) m_vld[k] <= 1'b0;
      end else begin
         m_vld[0] <= mul_rdy;
         m_dat[0] <= PW'(mul_a) * PW'(mul_b);
         for (int k = 1; k < LAT; k++) begin
            m_vld[k] <= m_vld[k-1];
            m_dat[k] <= m_dat[k-1];
         end
      end
   end

   assign mul_valid = m_vld[LAT-1] | force_valid;
   assign mul_dout  = m_dat[LAT-1];

   typedef struct {
      int            id;
      logic [PW-1:0] prod;
      int            due;
   } exp_t;

   exp_t sb[$];
   int   n_vec   = 0;
   int   n_err   = 0;
   int   cyc     = 0;
   logic exp_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance one clock and check everything registered.
   task automatic tick(input bit acc, input logic [M1-1:0] ea, input logic [M2-1:0] eb);
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      chk("mul_rdy", 32'(mul_rdy), 32'(acc));
      if (acc) begin
         chk("mul_a", 32'(mul_a), 32'(ea));
         chk("mul_b", 32'(mul_b), 32'(eb));
      end
      chk("err", 32'(err), 32'(exp_err));
      if (sb.size() > 0 && sb[0].due < cyc) begin
         chk("missed_rsp_cycle", 32'(cyc), 32'(sb[0].due));
         void'(sb.pop_front());
      end
      if (rsp_valid !== 4'b0000) begin
         if (sb.size() == 0) begin
            chk("stray_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
            chk("rsp_id",    32'(rsp_id),    32'(e.id));
            chk("rsp_data",  32'(rsp_data),  32'(e.prod));
            chk("rsp_cycle", 32'(cyc),       32'(e.due));
         end
      end
   endtask

   // Drive one cycle of inputs; g is the expected grant index or -1 for none.
   task automatic step(input logic r, input logic e, input logic [NREQ-1:0] v,
                       input logic [NREQ*M1-1:0] a, input logic [NREQ*M2-1:0] b,
                       input int g);
      logic [M1-1:0] ga;
      logic [M2-1:0] gb;
      exp_t          x;
      rst = r; en = e; req_valid = v; req_a = a; req_b = b;
      #1;
      chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      ga = '0;
      gb = '0;
      if (r) sb.delete();
      if (g >= 0) begin
         ga     = a[g*M1 +: M1];
         gb     = b[g*M2 +: M2];
         x.id   = g;
         x.prod = PW'(ga) * PW'(gb);
         x.due  = cyc + LAT + 2;
         sb.push_back(x);
      end
      tick(g >= 0, ga, gb);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'b0000, 32'd0, 32'd0, -1);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0; force_valid = 1'b0;

      // Reset held 3 cycles with random inputs.
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'($urandom), 4'($urandom), $urandom, $urandom, -1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id",    32'(rsp_id),    32'd0);
      chk("rst_rsp_data",  32'(rsp_data),  32'd0);
      chk("rst_mul_a",     32'(mul_a),     32'd0);

      // Full load: all request, a=16+i, b=10; first grant goes to 0.
      for (int i = 0; i < 8; i++)
         step(1'b0, 1'b1, 4'b1111, {8'd19, 8'd18, 8'd17, 8'd16}, {4{8'd10}}, i % 4);
      idle(LAT + 4);
      chk("drain_full", 32'(sb.size()), 32'd0);

      // Single request: 25*5 = 125 to requester 0.
      step(1'b0, 1'b1, 4'b0001, {24'd0, 8'd25}, {24'd0, 8'd5}, 0);
      idle(LAT + 4);
      chk("drain_single", 32'(sb.size()), 32'd0);

      // Round-robin wrap: 1 alone, then 1 and 3 -> 3 then 1.
      step(1'b0, 1'b1, 4'b0010, {16'd0, 8'd15, 8'd0}, {16'd0, 8'd7, 8'd0}, 1);
      step(1'b0, 1'b1, 4'b1010, {8'd9, 8'd0, 8'd15, 8'd0}, {8'd11, 8'd0, 8'd7, 8'd0}, 3);
      step(1'b0, 1'b1, 4'b0010, {8'd9, 8'd0, 8'd15, 8'd0}, {8'd11, 8'd0, 8'd7, 8'd0}, 1);
      idle(LAT + 4);
      chk("drain_rr", 32'(sb.size()), 32'd0);

      // Enable gating: requester 2 waits while en=0, then 10*4 = 40.
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, 4'b0100, {8'd0, 8'd10, 16'd0}, {8'd0, 8'd4, 16'd0}, -1);
      step(1'b0, 1'b1, 4'b0100, {8'd0, 8'd10, 16'd0}, {8'd0, 8'd4, 16'd0}, 2);
      idle(LAT + 4);
      chk("drain_en", 32'(sb.size()), 32'd0);

      // Reset mid-flight: three ops, reset two cycles later, nothing reported.
      step(1'b0, 1'b1, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd6}}, 3);
      step(1'b0, 1'b1, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd6}}, 0);
      step(1'b0, 1'b1, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd6}}, 1);
      idle(2);
      step(1'b1, 1'b1, 4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd6}}, -1);
      idle(LAT + 6);
      // Resume: pointer restarted at requester 0; full-width products.
      step(1'b0, 1'b1, 4'b1001, {8'd255, 16'd0, 8'd200}, {8'd255, 16'd0, 8'd250}, 0);
      step(1'b0, 1'b1, 4'b1001, {8'd255, 16'd0, 8'd200}, {8'd255, 16'd0, 8'd250}, 3);
      idle(LAT + 4);
      chk("drain_resume", 32'(sb.size()), 32'd0);

`ifdef MULT_ARB_TAG_CHECK_EN
      // Stray mul_valid with an empty tag pipe: sticky err, no response.
      force_valid = 1'b1;
      exp_err     = 1'b1;
      idle(1);
      force_valid = 1'b0;
      idle(4);
      exp_err = 1'b0;
      step(1'b1, 1'b1, 4'b0000, 32'd0, 32'd0, -1);
      idle(2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
